// File: rtl/glitcher_pkg.sv
// Shared types for the one-bit waveform link blocks.
// Holds the deserializer FSM state encoding and its default frame length.
package glitcher_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ARM   = 2'd1,
      SHIFT = 2'd2,
      HOLD  = 2'd3
   } deser_state_t;

   localparam int DESER_WIDTH_DEFAULT = 64;

endpackage

// File: rtl/deserializer64.sv
// MSB-first serial-to-parallel receiver with start alignment, bit qualifier,
// valid/ready word hold and sticky overrun detection.
module deserializer64
   import glitcher_pkg::*;
#(
   parameter int WIDTH = DESER_WIDTH_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic             sample_en,
   input  logic             din,
   output logic [WIDTH-1:0] data,
   output logic             valid,
   input  logic             ready,
   output logic             busy,
   output logic             overrun,
   input  logic             clr_overrun
);

   localparam int                   CNT_W    = $clog2(WIDTH + 1);
   localparam logic [CNT_W-1:0]     LAST_BIT = CNT_W'(WIDTH - 1);

   deser_state_t     state_q;
   // The oldest bit would shift straight out, so only WIDTH-1 bits are kept.
   logic [WIDTH-2:0] shift_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic [WIDTH-1:0] data_q;
   logic             valid_q;
   logic             busy_q;
   logic             overrun_q;

   logic [WIDTH-1:0] word_d;
   logic             overrun_set_d;

   assign word_d = {shift_q, din};

   always_comb begin
      overrun_set_d = 1'b0;
      if (start) begin
         case (state_q)
            ARM, SHIFT: overrun_set_d = 1'b1;
            HOLD:       overrun_set_d = ~ready;
            default:    overrun_set_d = 1'b0;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         data_q    <= '0;
         valid_q   <= 1'b0;
         busy_q    <= 1'b0;
         overrun_q <= 1'b0;
      end else begin
         // Set has priority over clear.
         overrun_q <= overrun_set_d | (overrun_q & ~clr_overrun);

         case (state_q)
            IDLE: begin
               if (start) begin
                  state_q   <= ARM;
                  shift_q   <= '0;
                  bit_cnt_q <= '0;
                  busy_q    <= 1'b1;
               end
            end
            ARM: begin
               state_q <= SHIFT;
            end
            SHIFT: begin
               if (sample_en) begin
                  shift_q   <= word_d[WIDTH-2:0];
                  bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                  if (bit_cnt_q == LAST_BIT) begin
                     data_q  <= word_d;
                     valid_q <= 1'b1;
                     busy_q  <= 1'b0;
                     state_q <= HOLD;
                  end
                end
            end
            HOLD: begin
               if (valid_q && ready) begin
                  valid_q <= 1'b0;
                  if (start) begin
                     state_q   <= ARM;
                     shift_q   <= '0;
                     bit_cnt_q <= '0;
                     busy_q    <= 1'b1;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data    = data_q;
   assign valid   = valid_q;
   assign busy    = busy_q;
   assign overrun = overrun_q;

endmodule
